// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler: round-robin arbiter sharing one 8N1 serial TX line.
// Ports: clk, reset (sync, active-high), enable, req_valid/req_data in,
//   req_ready (one-hot accept), serial_out, busy, grant_id, frame_done.
module serial_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 serial_out,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 frame_done
);

    localparam int DIV_W =
        (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD =
        DIV_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic            serial_q, serial_d;
    logic            done_q, done_d;

    logic            found;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] idx;
    logic            take;
    logic            bit_end;

    // Scan from the pointer upward, wrapping, first valid wins.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = ID_W'((int'(ptr_q) + off) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign take = (state_q == IDLE) && enable
                  && !reset && found;

    assign req_ready = take
        ? (NUM_REQ'(1) << win)
        : '0;

    assign bit_end = (div_q == '0);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        data_d   = data_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        serial_d = serial_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                if (take) begin
                    data_d   = req_data[int'(win)*8 +: 8];
                    grant_d  = win;
                    ptr_d    = ID_W'((int'(win) + 1) % NUM_REQ);
                    div_d    = DIV_RELOAD;
                    serial_d = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d  = DATA;
                    bit_d    = 3'd0;
                    div_d    = DIV_RELOAD;
                    serial_d = data_q[0];
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    div_d = DIV_RELOAD;
                    if (bit_q == 3'd7) begin
                        state_d  = STOP;
                        serial_d = 1'b1;
                    end else begin
                        bit_d    = bit_q + 3'd1;
                        serial_d = data_q[bit_q + 3'd1];
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    serial_d = 1'b1;
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                serial_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            ptr_q    <= '0;
            grant_q  <= '0;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            serial_q <= serial_d;
            done_q   <= done_d;
        end
    end

    assign serial_out = serial_q;
    assign busy       = (state_q != IDLE);
    assign grant_id   = grant_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// tb_serial_tx_scheduler: directed + random bench with a timeline model.
// Drives two builds: CLKS_PER_BIT=4 (main) and CLKS_PER_BIT=1.
module tb_serial_tx_scheduler;

    localparam int N = 4;
    localparam int C = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, enable;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           serial_out, busy, frame_done;
    logic [1:0]     grant_id;

    logic           reset1, en1;
    logic [N-1:0]   valid1;
    logic [N*8-1:0] data1;
    logic [N-1:0]   ready1;
    logic           serial1, busy1, done1;
    logic [1:0]     gid1;

    serial_tx_scheduler #(
        .NUM_REQ(N), .CLKS_PER_BIT(C)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .serial_out(serial_out),
        .busy(busy), .grant_id(grant_id),
        .frame_done(frame_done)
    );

    serial_tx_scheduler #(
        .NUM_REQ(N), .CLKS_PER_BIT(1)
    ) dut1 (
        .clk(clk), .reset(reset1), .enable(en1),
        .req_valid(valid1), .req_data(data1),
        .req_ready(ready1), .serial_out(serial1),
        .busy(busy1), .grant_id(gid1),
        .frame_done(done1)
    );

    int checks = 0;
    int errors = 0;

    // Model: a frame is a timeline anchored at its accept cycle.
    int         cyc   = 0;
    int         t_acc = -1;
    int         ptr   = 0;
    int         grant = 0;
    logic [7:0] mbyte = 8'h00;
    int         dut_acc[$];

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int d, b, w, i;
        logic bsy, es, ed;
        logic [N-1:0] er;
        @(negedge clk);
        d   = cyc - t_acc;
        bsy = (t_acc >= 0) && (d >= 1) && (d <= 10 * C);
        ed  = (t_acc >= 0) && (d == 10 * C + 1);
        es  = 1'b1;
        if (bsy) begin
            b = (d - 1) / C;
            if (b == 0) es = 1'b0;
            else if (b == 9) es = 1'b1;
            else es = mbyte[b-1];
        end
        w  = -1;
        er = '0;
        if (!bsy && enable && !reset) begin
            for (int j = 0; j < N; j++) begin
                i = (ptr + j) % N;
                if (w < 0 && req_valid[i]) w = i;
            end
        end
        if (w >= 0) er = N'(1) << w;
        chk("ready", 32'(req_ready), 32'(er));
        chk("serial", 32'(serial_out), 32'(es));
        chk("busy", 32'(busy), 32'(bsy));
        chk("done", 32'(frame_done), 32'(ed));
        chk("grant", 32'(grant_id), 32'(grant));
        if (req_ready != '0) dut_acc.push_back(cyc);
        @(posedge clk);
        if (reset) begin
            t_acc = -1;
            ptr   = 0;
            grant = 0;
        end else if (w >= 0) begin
            t_acc = cyc;
            grant = w;
            ptr   = (w + 1) % N;
            mbyte = req_data[8*w +: 8];
        end
        cyc++;
        #1;
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    task automatic wait_accept(int maxc);
        int n;
        n = dut_acc.size();
        for (int i = 0; i < maxc; i++) begin
            if (dut_acc.size() != n) break;
            tick();
        end
        chk("accept_timeout", 32'(dut_acc.size() - n), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int n0;
    int gids[5];

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        req_valid = '1;
        req_data  = '0;
        reset1    = 1'b1;
        en1       = 1'b1;
        valid1    = '0;
        data1     = '0;
        @(posedge clk);
        #1;
        ticks(3);

        // Single frame from requester 2, byte A5.
        reset     = 1'b0;
        req_valid = 4'b0100;
        req_data[23:16] = 8'hA5;
        wait_accept(4);
        chk("t1_gid", 32'(grant_id), 32'd2);
        req_valid = '0;
        req_data  = {$urandom};
        ticks(45);

        // All requesters valid: strict rotation, 41-cycle spacing.
        do_reset();
        req_valid = '1;
        n0 = dut_acc.size();
        for (int k = 0; k < 5; k++) begin
            wait_accept(50);
            gids[k] = int'(grant_id);
            req_data = {$urandom};
        end
        for (int k = 0; k < 5; k++)
            chk("t2_gid", 32'(gids[k]), 32'(k % N));
        for (int k = 1; k < 5; k++)
            chk("t2_gap",
                32'(dut_acc[n0+k] - dut_acc[n0+k-1]), 32'd41);
        req_valid = '0;
        ticks(45);

        // Pointer after grant to 1 is 2: 3 wins, then 0.
        do_reset();
        req_valid = 4'b0010;
        wait_accept(4);
        chk("t3_gid1", 32'(grant_id), 32'd1);
        req_valid = 4'b1001;
        wait_accept(50);
        chk("t3_gid3", 32'(grant_id), 32'd3);
        wait_accept(50);
        chk("t3_gid0", 32'(grant_id), 32'd0);
        req_valid = '0;
        ticks(45);

        // enable drops mid-frame.
        req_valid = '1;
        wait_accept(4);
        ticks(15);
        enable = 1'b0;
        n0 = dut_acc.size();
        ticks(60);
        chk("t4_no_grant", 32'(dut_acc.size() - n0), 32'd0);
        enable = 1'b1;
        tick();
        chk("t4_resume", 32'(dut_acc.size() - n0), 32'd1);
        req_valid = '0;
        ticks(45);

        // Reset during data bit 3.
        do_reset();
        req_valid = '1;
        req_data  = {$urandom};
        wait_accept(4);
        ticks(4 + 3 * C + 1);
        chk("t5_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_serial", 32'(serial_out), 32'd1);
        wait_accept(4);
        chk("t5_gid", 32'(grant_id), 32'd0);
        req_valid = '0;
        ticks(45);

        // Random traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 3) == 0)
                req_valid = N'($urandom);
            req_data = {$urandom};
            enable   = ($urandom_range(0, 9) != 0);
            reset    = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset     = 1'b0;
        enable    = 1'b1;
        req_valid = '0;
        ticks(45);

        // One-cycle-per-bit build, byte 00.
        reset1 = 1'b0;
        valid1 = 4'b0001;
        data1  = '0;
        #1;
        chk("c1_ready", 32'(ready1), 32'd1);
        tick();
        valid1 = '0;
        for (int k = 1; k <= 11; k++) begin
            chk("c1_serial", 32'(serial1),
                32'(k <= 9 ? 0 : 1));
            chk("c1_busy", 32'(busy1), 32'(k <= 10));
            chk("c1_done", 32'(done1), 32'(k == 11));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_tx_scheduler.md
Name: serial_tx_scheduler

Overview:
Shares one asynchronous serial transmit line between NUM_REQ byte producers, using round-robin arbitration. The block accepts one byte per frame through a valid/ready handshake and serializes it as start bit (0), 8 data bits LSB-first, then stop bit (1). The frame format matches the team's serial receiver. It sits between on-chip byte sources and the board-level serial pin.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
CLKS_PER_BIT, 4, clk cycles each serial bit is held (>=1)
ID_W, $clog2(NUM_REQ), width of grant_id

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  when low, no new frame is granted; an in-flight frame completes
req_valid  input  NUM_REQ  per-requester byte available
req_data  input  NUM_REQ*8  byte of requester i at [8*i+7:8*i]
req_ready  output  NUM_REQ  one-hot accept strobe, combinational
serial_out  output  1  serial line, registered, idle high
busy  output  1  high while a frame is in flight (start through stop bit)
grant_id  output  ID_W  index of the requester owning the current/last frame
frame_done  output  1  one-cycle pulse after the stop bit completes

Behaviour:
- Interface: reset is synchronous and active-high; the clock is clk.
- Reset values: serial_out=1, busy=0, grant_id=0, frame_done=0, RR pointer=0, state IDLE. req_ready=0 in any cycle where reset=1.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - serial_out=1.
  - If enable=1 and any req_valid=1, the winner is the first valid index scanning pointer, pointer+1, ... mod NUM_REQ.
  - req_ready[winner]=1 combinationally in that cycle; transfer occurs at that edge.
  - On transfer: latch req_data slice, grant_id<=winner, pointer<=(winner+1) mod NUM_REQ, next state START.
  - req_ready is never high outside IDLE. Requesters must not make valid depend on ready.
- START: serial_out=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - Bit k (k=0..7) of the latched byte is driven for CLKS_PER_BIT cycles each.
  - A 3-bit counter selects the bit; after bit 7, next state STOP.
- STOP: serial_out=1 for CLKS_PER_BIT cycles, then IDLE.
- frame_done=1 in the first IDLE cycle after STOP. That cycle may also accept a new request, so back-to-back frame period = 10*CLKS_PER_BIT+1 cycles.
- Latency: transfer at edge of cycle t -> start bit visible cycles t+1..t+CLKS_PER_BIT; stop bit ends at t+10*CLKS_PER_BIT; frame_done in cycle t+10*CLKS_PER_BIT+1.
- busy=1 exactly in START/DATA/STOP cycles.
- Divider counter width is max(1,$clog2(CLKS_PER_BIT)) and reloads at every bit boundary. CLKS_PER_BIT=1 gives one bit per cycle.
- Boundary conditions:
  - Changes to req_data/req_valid after transfer do not affect the frame.
  - enable falling mid-frame: the frame completes normally, frame_done still pulses, and no new grant is made while enable=0.
  - Pointer updates only on transfer, never on idle cycles.
  - Reset mid-frame: the frame is abandoned, serial_out=1 from the next cycle, no frame_done, pointer=0.
  - grant_id holds its last value in IDLE until the next transfer.

Test Plan:
1. CLKS_PER_BIT=4; req_valid=4'b0100, data[2]=0xA5 -> req_ready=4'b0100 for 1 cycle, grant_id=2; serial_out per 4-cycle bit = 0,1,0,1,0,0,1,0,1,1; frame_done at accept+41; busy high 40 cycles.
2. All req_valid=1 continuously -> grants 0,1,2,3,0 in order, accepts exactly 41 cycles apart, frame_done coincides with each next accept.
3. After a grant to 1 (pointer=2), req_valid=4'b1001 -> requester 3 wins; the next frame with both valid goes to 0.
4. enable dropped during DATA of a frame -> frame completes with frame_done; req_ready stays 0 while enable=0 despite valid; grant resumes the cycle enable returns to 1.
5. reset asserted during DATA bit 3 -> serial_out=1 next cycle, busy=0, no frame_done; with all valid after release, requester 0 is granted first.
6. CLKS_PER_BIT=1 build, byte 0x00 -> serial_out 0 for 9 consecutive cycles then 1; frame_done at accept+11.
